data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the core's data-memory interface (`mem_ren`/`mem_wen`/`mem_addr`/`mem_dout`/`mem_din`). It answers every core load/store from a word-addressed data RAM or a small memory-mapped I/O page. The I/O page holds a byte-output FIFO, drained through a valid/ready stream to a peripheral, and a free-running cycle counter. It sits beside the core in the top level, opposite the core's data port, and must never stall the core.

## Interface
- `ADDR_WIDTH`, 10, RAM word-address bits (RAM = 2^ADDR_WIDTH words).
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, 2..16.
- `clk`  in  1  main clock, rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `mem_ren`  in  1  core load request.
- `mem_wen`  in  1  core store request.
- `mem_addr`  in  32  byte address; bits [1:0] ignored.
- `mem_dout`  in  32  store data from core.
- `mem_din`  out  32  load data to core.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  peripheral accepts head.
- `out_data`  out  8  FIFO head byte.
- `bad_access`  out  1  sticky: access to an unmapped address seen.

## Operation
- Address map (word-aligned byte addresses):
  - RAM: `0x0000_0000` up to 4·2^ADDR_WIDTH−1.
  - OUT_DATA: `0xFFFF_FF00`.
  - STATUS: `0xFFFF_FF04`.
  - CYCLE: `0xFFFF_FF08`.
  - Everything else is unmapped.
- RAM:
  - Read is combinational from `mem_addr[ADDR_WIDTH+1:2]`.
  - Write commits on the clock edge with `mem_wen`.
  - Contents are not reset.
- OUT_DATA:
  - A store pushes `mem_dout[7:0]`.
  - A load returns 0.
  - A push while the FIFO is full is dropped and sets the sticky `overflow` bit, unless a pop happens in the same cycle. In that case the push is accepted and the count is unchanged.
- STATUS read: `{16'b0, count[7:0], 5'b0, overflow, full, empty}`.
  - A store with `mem_dout[2]`=1 clears `overflow`; all other store bits are ignored.
- CYCLE:
  - Increments every cycle and wraps from `0xFFFF_FFFF` to 0.
  - A store loads `mem_dout`, with no increment in that cycle.
  - A load returns the current value.
- Unmapped address:
  - A load returns 0.
  - A store is dropped.
  - Either access sets `bad_access`, which is cleared only by reset.
- `mem_din` = 0 whenever `mem_ren`=0.
- `mem_ren` and `mem_wen` both high: the write is performed, and `mem_din` returns the pre-write value.
- Stream handshake:
  - A pop occurs when `out_valid && out_ready`.
  - `out_valid` = !empty.
  - `out_data` is stable while `out_valid && !out_ready`.
  - Pops and pushes are in FIFO order.

## Timing
- Load latency 0: `mem_din` is combinational from `mem_addr`/`mem_ren` in the same cycle, as the core's MEM stage requires.
- Store effects are visible to a load in the next cycle.
- A FIFO push is visible on `out_valid`/`out_data` one cycle after the store edge (no bypass).
- Reset (async assert, sync-safe deassert) puts every output and all state in this condition:
  - FIFO empty, `out_valid`=0, `out_data`=0.
  - `count`=0, `overflow`=0, `bad_access`=0.
  - CYCLE=0.
  - `mem_din` follows its combinational rule.
- Reset mid-stream discards FIFO contents immediately; a handshake in flight is lost.
- Boundaries:
  - FIFO read/write pointers wrap modulo FIFO_DEPTH.
  - `count` spans 0..FIFO_DEPTH, using log2(FIFO_DEPTH)+1 bits, zero-extended to 8 bits in STATUS.

## Structure
- Address-map constants (`IO_OUT_DATA`, `IO_STATUS`, `IO_CYCLE`) and STATUS bit positions go in `define.vh`, shared with the software headers.
- One sub-module, `sync_fifo` (parameterised width/depth, push/pop/full/empty/count), instantiated with width 8.
- Address decode, RAM, CYCLE counter and sticky flags live in the top module.

## Test plan
- RAM: store `0xDEADBEEF` to `0x40`, then load `0x40` next cycle → `mem_din`=`0xDEADBEEF`; load `0x44` after reset-free init with a known preload → preload value.
- FIFO fill with `out_ready`=0 and FIFO_DEPTH=4:
  - Store 5 bytes `0x11`..`0x15` to OUT_DATA.
  - Expect STATUS=`0x0000_0406` (count 4, overflow, full).
  - Then raise `out_ready` → `out_data` sequence `0x11,0x12,0x13,0x14`, then `out_valid`=0 and STATUS=`0x0000_0005`.
- Full FIFO with `out_ready`=1 and a same-cycle store of `0x99` → push accepted, no overflow, `0x99` emerges last.
- CYCLE: store `0xFFFF_FFFE`; loads on the next three cycles → `0xFFFF_FFFE`, `0xFFFF_FFFF`, `0x0000_0000`.
- Unmapped load `0x8000_0000` → `mem_din`=0 and `bad_access`=1 next cycle; simultaneous `mem_ren`/`mem_wen` to RAM returns the old data.
- Assert `rst_n`=0 mid-drain with 3 entries queued → `out_valid`=0 immediately; after release, STATUS=`0x0000_0001` and CYCLE counts from 0.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared address map, STATUS bit layout and address-region decode for the
// data-memory responder.
package data_mem_responder_pkg;

  localparam logic [31:0] IO_OUT_DATA = 32'hFFFF_FF00;
  localparam logic [31:0] IO_STATUS   = 32'hFFFF_FF04;
  localparam logic [31:0] IO_CYCLE    = 32'hFFFF_FF08;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_OVF_BIT   = 2;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_OUT_DATA,
    RGN_STATUS,
    RGN_CYCLE,
    RGN_NONE
  } region_e;

  // Byte-offset bits are not part of the decode; callers pass the word address.
  function automatic region_e decode_region(input logic [31:2] word_addr, input int aw);
    logic [31:0] a;
    a = {word_addr, 2'b00};
    if (a == IO_OUT_DATA)              return RGN_OUT_DATA;
    else if (a == IO_STATUS)           return RGN_STATUS;
    else if (a == IO_CYCLE)            return RGN_CYCLE;
    else if ((a >> (aw + 2)) == 32'd0) return RGN_RAM;
    else                               return RGN_NONE;
  endfunction

endpackage

// File: rtl/data_mem_responder_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is taken
// only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Head is forced to zero when empty so stale storage never leaks out.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: zero-latency loads from word RAM or the I/O page
// (byte-output FIFO, STATUS, free-running CYCLE counter).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        bad_access
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  region_e               rgn;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [31:0]           ram_q [2**ADDR_WIDTH];
  logic                  ram_we;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [7:0]            fifo_head;

  logic                  overflow_q, overflow_d;
  logic                  bad_access_q, bad_access_d;
  logic [31:0]           cycle_q, cycle_d;
  logic [31:0]           status_word;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^mem_addr[1:0];

  assign rgn     = decode_region(mem_addr[31:2], ADDR_WIDTH);
  assign ram_idx = mem_addr[ADDR_WIDTH+1:2];
  assign ram_we  = mem_wen && (rgn == RGN_RAM);

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= mem_dout;
  end

  assign fifo_push = mem_wen && (rgn == RGN_OUT_DATA);
  assign fifo_pop  = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (mem_dout[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_head;
  assign bad_access = bad_access_q;

  always_comb begin
    overflow_d   = overflow_q;
    bad_access_d = bad_access_q;
    cycle_d      = cycle_q + 32'd1;
    // Overflow only when the push is actually dropped (no pop to make room).
    if (fifo_push && fifo_full && !fifo_pop)
      overflow_d = 1'b1;
    else if (mem_wen && (rgn == RGN_STATUS) && mem_dout[ST_OVF_BIT])
      overflow_d = 1'b0;
    if ((mem_ren || mem_wen) && (rgn == RGN_NONE))
      bad_access_d = 1'b1;
    if (mem_wen && (rgn == RGN_CYCLE))
      cycle_d = mem_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q   <= 1'b0;
      bad_access_q <= 1'b0;
      cycle_q      <= 32'd0;
    end else begin
      overflow_q   <= overflow_d;
      bad_access_q <= bad_access_d;
      cycle_q      <= cycle_d;
    end
  end

  always_comb begin
    status_word                       = 32'd0;
    status_word[ST_COUNT_LSB +: 8]    = 8'(fifo_count);
    status_word[ST_OVF_BIT]           = overflow_q;
    status_word[ST_FULL_BIT]          = fifo_full;
    status_word[ST_EMPTY_BIT]         = fifo_empty;
  end

  // Reads come from current state, so a same-cycle store returns old data.
  always_comb begin
    mem_din = 32'd0;
    if (mem_ren) begin
      case (rgn)
        RGN_RAM:    mem_din = ram_q[ram_idx];
        RGN_STATUS: mem_din = status_word;
        RGN_CYCLE:  mem_din = cycle_q;
        default:    mem_din = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM, FIFO fill/drain/overflow,
// CYCLE wrap, unmapped access and mid-stream reset.
module tb_data_mem_responder;

  localparam logic [31:0] A_OUT  = 32'hFFFF_FF00;
  localparam logic [31:0] A_STAT = 32'hFFFF_FF04;
  localparam logic [31:0] A_CYC  = 32'hFFFF_FF08;

  logic        clk;
  logic        rst_n;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        out_valid, out_ready, bad_access;
  logic [7:0]  out_data;

  logic [7:0]  exp_q[$];
  int          n_cmp;
  int          n_err;

  data_mem_responder #(
    .ADDR_WIDTH (10),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .bad_access (bad_access)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // drivers: all called at a falling edge; step advances one full cycle
  task automatic step();
    @(negedge clk);
    mem_ren = 1'b0;
    mem_wen = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    mem_wen  = 1'b1;
    mem_addr = addr;
    mem_dout = data;
  endtask

  task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    mem_ren  = 1'b1;
    mem_addr = addr;
    #1;
    check_eq(tag, mem_din, exp);
  endtask

  task automatic head_chk(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    #1;
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_data"}, {24'd0, out_data}, {24'd0, e});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    mem_addr = 32'd0;
    mem_dout = 32'd0;
    out_ready = 1'b0;
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
    check_eq("rst_bad_access", {31'd0, bad_access}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    rd_chk(A_CYC, 32'd0, "cycle_after_rst"); step();
    rd_chk(A_CYC, 32'd1, "cycle_plus1"); step();
    rd_chk(A_STAT, 32'h0000_0001, "status_rst"); step();

    // RAM store/load, preload for after-reset check, ren=0 gating
    wr(32'h40, 32'hDEAD_BEEF); step();
    rd_chk(32'h40, 32'hDEAD_BEEF, "ram_40"); step();
    wr(32'h44, 32'h1234_5678); step();
    rd_chk(32'h44, 32'h1234_5678, "ram_44"); step();
    mem_addr = 32'h40;
    #1;
    check_eq("din_zero_no_ren", mem_din, 32'd0);
    wr(32'h40, 32'hCAFE_F00D);
    rd_chk(32'h40, 32'hDEAD_BEEF, "rw_old_data"); step();
    rd_chk(32'h40, 32'hCAFE_F00D, "rw_new_data"); step();
    rd_chk(A_OUT, 32'd0, "out_data_load_zero"); step();

    // FIFO fill with overflow, then drain
    for (int i = 0; i < 5; i++) begin
      wr(A_OUT, 32'h11 + i);
      if (i < 4) exp_q.push_back(8'h11 + 8'(i));
      step();
    end
    rd_chk(A_STAT, 32'h0000_0406, "status_full_ovf"); step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      head_chk("drain");
      step();
    end
    #1;
    check_eq("drain_empty", {31'd0, out_valid}, 32'd0);
    rd_chk(A_STAT, 32'h0000_0005, "status_empty_ovf"); step();
    wr(A_STAT, 32'h0000_0004); step();
    rd_chk(A_STAT, 32'h0000_0001, "status_ovf_clr"); step();

    // full FIFO with simultaneous pop and push
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr(A_OUT, 32'h21 + i);
      exp_q.push_back(8'h21 + 8'(i));
      step();
    end
    exp_q.push_back(8'h99);
    rd_chk(A_STAT, 32'h0000_0402, "status_full"); step();
    out_ready = 1'b1;
    wr(A_OUT, 32'h99);
    head_chk("popush_head");
    step();
    rd_chk(A_STAT, 32'h0000_0402, "status_popush_no_ovf");
    for (int i = 0; i < 4; i++) begin
      head_chk("popush_drain");
      step();
    end
    #1;
    check_eq("popush_empty", {31'd0, out_valid}, 32'd0);
    rd_chk(A_STAT, 32'h0000_0001, "status_popush_end"); step();
    out_ready = 1'b0;

    // CYCLE load and wrap
    wr(A_CYC, 32'hFFFF_FFFE); step();
    rd_chk(A_CYC, 32'hFFFF_FFFE, "cycle_load"); step();
    rd_chk(A_CYC, 32'hFFFF_FFFF, "cycle_max"); step();
    rd_chk(A_CYC, 32'h0000_0000, "cycle_wrap"); step();

    // unmapped access
    rd_chk(32'h8000_0000, 32'd0, "unmapped_load");
    check_eq("bad_before_edge", {31'd0, bad_access}, 32'd0);
    step();
    #1;
    check_eq("bad_sticky", {31'd0, bad_access}, 32'd1);
    wr(32'hFFFF_FF0C, 32'h5555_5555); step();
    rd_chk(32'h40, 32'hCAFE_F00D, "ram_after_unmapped"); step();

    // reset mid-drain with 3 entries queued
    for (int i = 0; i < 4; i++) begin
      wr(A_OUT, 32'h31 + i);
      step();
    end
    exp_q.delete();
    exp_q.push_back(8'h31);
    out_ready = 1'b1;
    head_chk("pre_rst_head");
    step();
    out_ready = 1'b0;
    rd_chk(A_STAT, 32'h0000_0300, "status_three");
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_out_data", {24'd0, out_data}, 32'd0);
    check_eq("midrst_bad_access", {31'd0, bad_access}, 32'd0);
    check_eq("midrst_status_din", mem_din, 32'h0000_0001);
    step();
    step();
    rst_n = 1'b1;
    rd_chk(A_CYC, 32'd0, "cycle_post_rst0"); step();
    rd_chk(A_CYC, 32'd1, "cycle_post_rst1"); step();
    rd_chk(A_STAT, 32'h0000_0001, "status_post_rst"); step();
    rd_chk(32'h44, 32'h1234_5678, "ram_preload_kept"); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
